// File: rtl/status_cond_unit_pkg.sv
// status_cond_unit_pkg: shared widths, NZCV bit positions and condition codes
// for the EXE-stage status/condition logic.
package status_cond_unit_pkg;
   localparam int STAT_W = 4;
   localparam int COND_W = 4;
   localparam int STAT_Z = 3;
   localparam int STAT_C = 2;
   localparam int STAT_N = 1;
   localparam int STAT_V = 0;
   typedef enum logic [COND_W-1:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_e;
endpackage

// File: rtl/status_cond_unit_cond_check.sv
// status_cond_unit_cond_check: evaluates a 4-bit condition code against NZCV
// flags; purely combinational so branch logic can reuse it.
module status_cond_unit_cond_check
   import status_cond_unit_pkg::*;
(
   input  logic [COND_W-1:0] cond,
   input  logic [STAT_W-1:0] flags,
   output logic              pass
);
   logic z, c, n, v, base;
   // Codes come in true/inverted pairs, so cond[0] just flips the even code's test.
   always_comb begin
      z = flags[STAT_Z];
      c = flags[STAT_C];
      n = flags[STAT_N];
      v = flags[STAT_V];
      base = 1'b1;
      case (cond[COND_W-1:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         3'd7: base = 1'b1;
      endcase
      pass = base ^ cond[0];
   end
endmodule

// File: rtl/status_cond_unit.sv
// status_cond_unit: NZCV register, carry feedback, ID condition check and flag hazard stall.
// Define STATUS_BYPASS_EN to forward EXE status to the check and drop the stall.
module status_cond_unit
   import status_cond_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              exe_valid,
   input  logic              exe_s_bit,
   input  logic [STAT_W-1:0] status_in,
   input  logic              id_valid,
   input  logic [COND_W-1:0] id_cond,
   output logic [STAT_W-1:0] status_out,
   output logic              carry_out,
   output logic              cond_stall,
   output logic              exe_cond_ok
);
   logic [STAT_W-1:0] status_d, status_q, flags;
   logic              cond_ok_d, cond_ok_q, pass, s_upd;
   assign s_upd = exe_valid & exe_s_bit;
`ifdef STATUS_BYPASS_EN
   assign flags      = s_upd ? status_in : status_q;
   assign cond_stall = 1'b0;
`else
   assign flags      = status_q;
   assign cond_stall = id_valid & s_upd & (id_cond != COND_AL) & ~flush;
`endif
   status_cond_unit_cond_check u_cond_check (
      .cond  (id_cond),
      .flags (flags),
      .pass  (pass)
   );
   // flush does not block the flag write: the EXE instruction is older than the branch victim.
   always_comb begin
      status_d  = (s_upd & ~freeze) ? status_in : status_q;
      cond_ok_d = flush ? 1'b0 : freeze ? cond_ok_q : cond_stall ? 1'b0 : id_valid & pass;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         status_q  <= '0;
         cond_ok_q <= 1'b0;
      end else begin
         status_q  <= status_d;
         cond_ok_q <= cond_ok_d;
      end
   end
   assign status_out  = status_q;
   assign carry_out   = status_q[STAT_C];
   assign exe_cond_ok = cond_ok_q;
endmodule

// File: tb/tb_status_cond_unit.sv
// tb_status_cond_unit: scoreboard bench for status_cond_unit; expectations come
// from a reference model evaluated when stimulus is applied.
module tb_status_cond_unit;
`ifdef STATUS_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst, freeze, flush, exe_valid, exe_s_bit, id_valid;
   logic [3:0] status_in, id_cond, status_out;
   logic       carry_out, cond_stall, exe_cond_ok;
   int         total = 0, bad = 0;
   logic [3:0] m_status = 4'b0000;
   logic       m_ok = 1'b0;
   typedef struct {
      logic [3:0] st;
      logic       ok;
      string      nm;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   status_cond_unit dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .exe_valid(exe_valid), .exe_s_bit(exe_s_bit), .status_in(status_in),
      .id_valid(id_valid), .id_cond(id_cond), .status_out(status_out),
      .carry_out(carry_out), .cond_stall(cond_stall), .exe_cond_ok(exe_cond_ok)
   );

   always #5 clk = ~clk;

   function automatic bit pass_ref(input logic [3:0] c, input logic [3:0] f);
      bit z = f[3], cy = f[2], n = f[1], v = f[0];
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !cy || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit stall_ref();
      return !BYP && id_valid && exe_valid && exe_s_bit && id_cond != 4'hE && !flush;
   endfunction

   task automatic tick(input string nm);
      exp_t x;
      logic [3:0] f = (BYP && exe_valid && exe_s_bit) ? status_in : m_status;
      x.nm = nm;
      x.st = rst ? 4'b0000 : (exe_valid && exe_s_bit && !freeze) ? status_in : m_status;
      x.ok = rst ? 1'b0 : flush ? 1'b0 : freeze ? m_ok : stall_ref() ? 1'b0
                  : (id_valid && pass_ref(id_cond, f));
      m_status = x.st;
      m_ok = x.ok;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ev, input logic s, input logic [3:0] st,
                        input logic iv, input logic [3:0] c);
      exe_valid = ev; exe_s_bit = s; status_in = st; id_valid = iv; id_cond = c;
   endtask

   task automatic test_reset();
      rst = 1'b1; freeze = 1'b0; flush = 1'b0;
      drive(1'b1, 1'b1, 4'b1111, 1'b1, 4'hE);
      for (int i = 0; i < 2; i++) begin
         tick("reset");
         e = sb.pop_front(); total++;
         if ({status_out, carry_out, exe_cond_ok} !== {4'b0000, 1'b0, 1'b0}) begin
            bad++; $display("FAIL %s: got st=%b c=%b ok=%b want st=0000 c=0 ok=0",
                            e.nm, status_out, carry_out, exe_cond_ok);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_update();
      drive(1'b1, 1'b1, 4'b0100, 1'b0, 4'h0);
      tick("update_s");
      drive(1'b1, 1'b0, 4'b1011, 1'b0, 4'h0);
      tick("update_no_s");
      for (int i = 0; i < 2; i++) begin
         e = sb.pop_front(); total++;
         if ({status_out, carry_out} !== {4'b0100, 1'b1} || exe_cond_ok !== e.ok) begin
            bad++; $display("FAIL %s: got st=%b c=%b ok=%b want st=0100 c=1 ok=%b",
                            e.nm, status_out, carry_out, exe_cond_ok, e.ok);
         end
         if (i == 0) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_cond_sweep();
      for (int f = 0; f < 16; f++) begin
         drive(1'b1, 1'b1, 4'(f), 1'b0, 4'h0);
         tick("sweep_load");
         e = sb.pop_front(); total++;
         if (status_out !== e.st || exe_cond_ok !== e.ok) begin
            bad++; $display("FAIL %s: got st=%b ok=%b want st=%b ok=%b",
                            e.nm, status_out, exe_cond_ok, e.st, e.ok);
         end
         for (int c = 0; c < 16; c++) begin
            drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'(c));
            tick($sformatf("sweep_f%b_c%0d", 4'(f), c));
            e = sb.pop_front(); total++;
            if ({status_out, carry_out, exe_cond_ok} !== {e.st, e.st[2], e.ok}) begin
               bad++; $display("FAIL %s: got st=%b c=%b ok=%b want st=%b c=%b ok=%b",
                               e.nm, status_out, carry_out, exe_cond_ok, e.st, e.st[2], e.ok);
            end
         end
      end
   endtask

   task automatic test_hazard(input logic fl);
      string nm = fl ? "flush_vs_stall" : "hazard";
      logic exp_stall = !BYP && !fl;
      drive(1'b1, 1'b1, 4'b0000, 1'b0, 4'h0);
      tick({nm, "_clear"});
      void'(sb.pop_front());
      drive(1'b1, 1'b1, 4'b1000, 1'b1, 4'h0);
      flush = fl;
      #1; total++;
      if (cond_stall !== exp_stall) begin
         bad++; $display("FAIL %s_stall: got %b want %b", nm, cond_stall, exp_stall);
      end
      tick({nm, "_bubble"});
      flush = 1'b0;
      e = sb.pop_front(); total++;
      if ({status_out, exe_cond_ok} !== {4'b1000, BYP && !fl}) begin
         bad++; $display("FAIL %s: got st=%b ok=%b want st=1000 ok=%b",
                         e.nm, status_out, exe_cond_ok, BYP && !fl);
      end
      drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'h0);
      #1; total++;
      if (cond_stall !== 1'b0) begin
         bad++; $display("FAIL %s_stall_end: got %b want 0", nm, cond_stall);
      end
      tick({nm, "_after"});
      e = sb.pop_front(); total++;
      if ({status_out, exe_cond_ok} !== {4'b1000, 1'b1} || e.ok !== 1'b1) begin
         bad++; $display("FAIL %s: got st=%b ok=%b want st=1000 ok=1",
                         e.nm, status_out, exe_cond_ok);
      end
   endtask

   task automatic test_freeze();
      drive(1'b1, 1'b1, 4'b0000, 1'b1, 4'hF);
      tick("freeze_pre");
      void'(sb.pop_front());
      freeze = 1'b1;
      drive(1'b1, 1'b1, 4'b0110, 1'b1, 4'hE);
      for (int i = 0; i < 3; i++) begin
         tick("freeze_hold");
         e = sb.pop_front(); total++;
         if ({status_out, exe_cond_ok} !== {4'b0000, 1'b0}) begin
            bad++; $display("FAIL %s: got st=%b ok=%b want st=0000 ok=0",
                            e.nm, status_out, exe_cond_ok);
         end
      end
      freeze = 1'b0;
      tick("freeze_release");
      e = sb.pop_front(); total++;
      if ({status_out, carry_out, exe_cond_ok} !== {4'b0110, 1'b1, 1'b1}) begin
         bad++; $display("FAIL %s: got st=%b c=%b ok=%b want st=0110 c=1 ok=1",
                         e.nm, status_out, carry_out, exe_cond_ok);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] seq [3] = '{4'b0001, 4'b0010, 4'b1100};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, seq[i], 1'b1, 4'hE);
         tick($sformatf("b2b_%0d", i));
         e = sb.pop_front(); total++;
         if ({status_out, exe_cond_ok} !== {seq[i], 1'b1} || e.st !== seq[i]) begin
            bad++; $display("FAIL %s: got st=%b ok=%b want st=%b ok=1",
                            e.nm, status_out, exe_cond_ok, seq[i]);
         end
      end
      drive(1'b0, 1'b1, 4'b0011, 1'b1, 4'h0);
      tick("b2b_hold");
      e = sb.pop_front(); total++;
      if ({status_out, exe_cond_ok} !== {4'b1100, 1'b1}) begin
         bad++; $display("FAIL %s: got st=%b ok=%b want st=1100 ok=1",
                         e.nm, status_out, exe_cond_ok);
      end
   endtask

   task automatic test_rst_mid_stall();
      drive(1'b1, 1'b1, 4'b1000, 1'b1, 4'h0);
      rst = 1'b1;
      tick("rst_mid_stall");
      rst = 1'b0;
      e = sb.pop_front(); total++;
      if ({status_out, exe_cond_ok} !== {4'b0000, 1'b0}) begin
         bad++; $display("FAIL %s: got st=%b ok=%b want st=0000 ok=0",
                         e.nm, status_out, exe_cond_ok);
      end
      drive(1'b0, 1'b0, 4'b0000, 1'b1, 4'h1);
      tick("rst_fresh");
      e = sb.pop_front(); total++;
      if ({status_out, exe_cond_ok} !== {4'b0000, 1'b1}) begin
         bad++; $display("FAIL %s: got st=%b ok=%b want st=0000 ok=1",
                         e.nm, status_out, exe_cond_ok);
      end
   endtask

   initial begin
      test_reset();
      test_update();
      test_cond_sweep();
      test_hazard(1'b0);
      test_hazard(1'b1);
      test_freeze();
      test_back_to_back();
      test_rst_mid_stall();
      total++;
      if (sb.size() !== 0) begin
         bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/status_cond_unit.md
Name: status_cond_unit

Overview:
- Sits in the EXE stage, directly downstream of the ALU.
- Captures the ALU's 4-bit status into the architectural NZCV register when the executing instruction has its S bit set.
- Feeds the C flag back to the ALU as carry-in.
- Evaluates the 4-bit condition field of the instruction in ID, and registers the result as the EXE-stage "execute enable" that gates writeback.
- Stalls ID when a flag-setting instruction in EXE has not yet updated the register a conditional instruction depends on.

Parameters:
- COND_W, 4, width of condition field.
- STAT_W, 4, width of status vector.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- freeze  input  1  external hazard stall; holds all state.
- flush  input  1  branch taken; kills the ID instruction.
- exe_valid  input  1  EXE holds a valid instruction.
- exe_s_bit  input  1  EXE instruction updates flags.
- status_in  input  STAT_W  ALU status, packed {Z,C,N,V} ([3]=Z, [2]=C, [1]=N, [0]=V).
- id_valid  input  1  ID holds a valid instruction.
- id_cond  input  COND_W  condition field of the ID instruction.
- status_out  output  STAT_W  registered NZCV, same packing as status_in.
- carry_out  output  1  status_out[2]; drives ALU carry_in.
- cond_stall  output  1  request ID/IF hold and bubble into EXE.
- exe_cond_ok  output  1  registered: EXE instruction passed its condition.

Behaviour:
- Reset (rst=1 at clock edge): status_out=4'b0000, exe_cond_ok=0. cond_stall is combinational, so it is 0 whenever its enabling inputs are 0.
- Status update:
  - At a clock edge with exe_valid & exe_s_bit & ~freeze, status_out <= status_in.
  - Otherwise status_out holds.
  - flush does not block the update, because the EXE instruction is older than the branch victim.
- carry_out = status_out[2], combinational from the register.
- Condition check, evaluated on the effective flags F (see Optional Feature). Codes:
  - 0000 EQ Z; 0001 NE ~Z.
  - 0010 CS C; 0011 CC ~C.
  - 0100 MI N; 0101 PL ~N.
  - 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z.
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 NV 0.
- cond_stall (no bypass) = id_valid & exe_valid & exe_s_bit & (id_cond != 1110) & ~flush.
  - AL never stalls.
  - The stall lasts exactly 1 cycle when the flag-setting instruction moves on normally.
- exe_cond_ok register, priority rst > flush > freeze > cond_stall > normal:
  - rst: 0.
  - flush: 0.
  - freeze: hold.
  - cond_stall: 0 (bubble).
  - normal: id_valid & pass(id_cond, F).
- Simultaneous events:
  - flush with cond_stall: flush wins and cond_stall is deasserted.
  - freeze with an S update: no update.
  - rst mid-stall: all cleared; the next cycle evaluates fresh.
- Back-to-back S instructions: each updates in turn; the last writer wins.

Optional Feature:
- Macro STATUS_BYPASS_EN.
- Defined:
  - F = (exe_valid & exe_s_bit) ? status_in : status_out.
  - cond_stall tied to 0.
  - Conditional instructions immediately after a flag-setter proceed with no bubble.
- Undefined:
  - F = status_out.
  - cond_stall as specified in Behaviour.
- carry_out is unaffected in both builds.

Decomposition:
- Shared package/header holds:
  - condition code constants (COND_EQ .. COND_NV);
  - status bit index constants (STAT_Z=3, STAT_C=2, STAT_N=1, STAT_V=0);
  - STAT_W and COND_W.
- One combinational sub-module, cond_check: inputs cond and flags, output pass. It is reusable by branch logic.

Test Plan:
- Reset: hold rst 2 cycles with status_in=4'b1111, exe_valid=exe_s_bit=1 -> status_out=0000, exe_cond_ok=0.
- Update gating:
  - status_in=0100, exe_valid=1, exe_s_bit=1 -> status_out=0100 next cycle, carry_out=1.
  - Same inputs with exe_s_bit=0 -> status_out unchanged.
- Condition sweep: for each flag vector 0000..1111 and each id_cond 0..15, with no S in EXE -> exe_cond_ok matches the condition table, including AL=1 and NV=0.
- Hazard (no bypass): status_out=0000, EXE instruction has S with status_in=1000, ID cond=EQ:
  - cond_stall=1 for 1 cycle;
  - exe_cond_ok=0 (bubble);
  - the following cycle exe_cond_ok=1.
  - With STATUS_BYPASS_EN: no stall, exe_cond_ok=1 immediately.
- flush vs stall: same hazard as above with flush=1 -> cond_stall=0, exe_cond_ok=0, status_out still becomes 1000.
- freeze: freeze=1 with a pending S update and id_cond=AL -> status_out and exe_cond_ok hold for the freeze duration, then update on release.
